// File: rtl/spi_slave_port.sv
// SPI mode-0 slave: oversampled pins, RX FIFO, one-entry TX holding register.
// Optional SPI_SLAVE_LSB_FIRST_EN shifts both directions LSB first.
module spi_slave_port #(
  parameter int          FIFO_DEPTH = 4,
  parameter logic [7:0]  IDLE_BYTE  = 8'hFF
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       spi_sclk_i,
  input  logic       spi_ss_i,
  input  logic       spi_mosi_i,
  output logic       spi_miso_o,
  output logic       spi_miso_oe_o,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  input  logic       rx_ready_i,
  input  logic [7:0] tx_data_i,
  input  logic       tx_valid_i,
  output logic       tx_ready_o,
  output logic       overrun_o,
  output logic       underrun_o,
  output logic       frame_err_o,
  input  logic       clr_flags_i
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT
  } state_t;

  state_t state, state_n;

  logic [2:0] sclk_q;
  logic [2:0] ss_q;
  logic [1:0] mosi_q;
  logic       sclk_rise, sclk_fall;
  logic       ss_rise, ss_fall;
  logic       mosi_s;

  logic [7:0] shift_rx, shift_tx;
  logic [2:0] bit_cnt;
  logic       byte_done;
  logic [7:0] hold;
  logic       hold_full;

  logic       miso_oe, tx_load, tx_shift, rx_shift, abort;
  logic [7:0] tx_src, rx_next, tx_next;
  logic       load_bit, shift_bit;

  logic [7:0] mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr, rd_ptr, wr_n, rd_n;
  logic        full, pop, push_req, do_push, ovf;
  logic [7:0]  head_n;

  // Two-flop synchronisers plus one stage for edge detection
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sclk_q <= 3'b000;
      ss_q   <= 3'b111;
      mosi_q <= 2'b00;
    end else begin
      sclk_q <= {sclk_q[1:0], spi_sclk_i};
      ss_q   <= {ss_q[1:0], spi_ss_i};
      mosi_q <= {mosi_q[0], spi_mosi_i};
    end
  end

  assign sclk_rise = sclk_q[1] & ~sclk_q[2];
  assign sclk_fall = ~sclk_q[1] & sclk_q[2];
  assign ss_rise   = ss_q[1] & ~ss_q[2];
  assign ss_fall   = ~ss_q[1] & ss_q[2];
  assign mosi_s    = mosi_q[1];

  assign tx_src = hold_full ? hold : IDLE_BYTE;

`ifdef SPI_SLAVE_LSB_FIRST_EN
  assign rx_next   = {mosi_s, shift_rx[7:1]};
  assign tx_next   = {1'b0, shift_tx[7:1]};
  assign load_bit  = tx_src[0];
  assign shift_bit = shift_tx[1];
`else
  assign rx_next   = {shift_rx[6:0], mosi_s};
  assign tx_next   = {shift_tx[6:0], 1'b0};
  assign load_bit  = tx_src[7];
  assign shift_bit = shift_tx[6];
`endif

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= S_IDLE;
    else       state <= state_n;
  end

  // Next-state logic; ss_rise wins over any SCLK edge
  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE:  if (ss_fall) state_n = S_LOAD;
      S_LOAD:  state_n = ss_rise ? S_IDLE : S_SHIFT;
      S_SHIFT: if (ss_rise) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // Per-state strobes for the shift datapath
  always_comb begin
    miso_oe  = 1'b0;
    tx_load  = 1'b0;
    tx_shift = 1'b0;
    rx_shift = 1'b0;
    abort    = 1'b0;
    unique case (state)
      S_IDLE: ;
      S_LOAD: begin
        miso_oe = 1'b1;
        tx_load = 1'b1;
      end
      S_SHIFT: begin
        miso_oe = 1'b1;
        if (ss_rise) begin
          abort = 1'b1;
        end else begin
          rx_shift = sclk_rise;
          tx_load  = sclk_fall & byte_done;
          tx_shift = sclk_fall & ~byte_done;
        end
      end
      default: ;
    endcase
  end

  assign spi_miso_oe_o = miso_oe;

  // Shift registers, bit counter and frame error pulse
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      shift_rx    <= 8'h00;
      shift_tx    <= 8'h00;
      spi_miso_o  <= 1'b0;
      bit_cnt     <= 3'd0;
      byte_done   <= 1'b0;
      frame_err_o <= 1'b0;
    end else begin
      frame_err_o <= 1'b0;
      if (state == S_IDLE) begin
        bit_cnt    <= 3'd0;
        byte_done  <= 1'b0;
        spi_miso_o <= 1'b0;
      end
      if (abort) begin
        bit_cnt     <= 3'd0;
        byte_done   <= 1'b0;
        frame_err_o <= (bit_cnt != 3'd0);
      end
      if (rx_shift) begin
        shift_rx <= rx_next;
        if (bit_cnt == 3'd7) begin
          bit_cnt   <= 3'd0;
          byte_done <= 1'b1;
        end else begin
          bit_cnt <= bit_cnt + 3'd1;
        end
      end
      if (tx_load) begin
        shift_tx   <= tx_src;
        spi_miso_o <= load_bit;
        byte_done  <= 1'b0;
      end else if (tx_shift) begin
        shift_tx   <= tx_next;
        spi_miso_o <= shift_bit;
      end
    end
  end

  // TX holding register; a reload sees the content from before this cycle
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hold      <= 8'h00;
      hold_full <= 1'b0;
    end else begin
      if (tx_load && hold_full) hold_full <= 1'b0;
      if (tx_valid_i && !hold_full) begin
        hold      <= tx_data_i;
        hold_full <= 1'b1;
      end
    end
  end

  assign tx_ready_o = ~hold_full;

  // Sticky error flags; a new event beats a clear
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      overrun_o  <= 1'b0;
      underrun_o <= 1'b0;
    end else begin
      if (ovf)              overrun_o <= 1'b1;
      else if (clr_flags_i) overrun_o <= 1'b0;
      if (tx_load && !hold_full) underrun_o <= 1'b1;
      else if (clr_flags_i)      underrun_o <= 1'b0;
    end
  end

  assign push_req = rx_shift & (bit_cnt == 3'd7);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) &&
                    (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop      = rx_ready_i & rx_valid_o;
  assign do_push  = push_req & (~full | pop);
  assign ovf      = push_req & full & ~pop;

  // Next pointers and next head, bypassing a byte written into the head slot
  always_comb begin
    wr_n = wr_ptr;
    rd_n = rd_ptr;
    if (do_push) wr_n = wr_ptr + PTR_ONE;
    if (pop)     rd_n = rd_ptr + PTR_ONE;
    head_n = mem[rd_n[AW-1:0]];
    if (do_push && (rd_n == wr_ptr)) head_n = rx_next;
  end

  // RX FIFO storage
  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= rx_next;
  end

  // RX FIFO pointers and registered head
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      rx_valid_o <= 1'b0;
      rx_data_o  <= 8'h00;
    end else begin
      wr_ptr     <= wr_n;
      rd_ptr     <= rd_n;
      rx_valid_o <= (wr_n != rd_n);
      if (wr_n != rd_n) rx_data_o <= head_n;
    end
  end

endmodule

// File: tb/tb_spi_slave_port.sv
// Directed bench for spi_slave_port: SPI master model on the pins,
// fabric-side pops and TX loads, hand-computed expectations.
module tb_spi_slave_port;

  logic       clk = 1'b0;
  logic       rst;
  logic       sclk, ss, mosi;
  logic       miso, miso_oe;
  logic [7:0] rx_data;
  logic       rx_valid, rx_ready;
  logic [7:0] tx_data;
  logic       tx_valid, tx_ready;
  logic       overrun, underrun, frame_err, clr_flags;

  int n_tests = 0;
  int n_fail  = 0;
  int err_cnt = 0;

  spi_slave_port #(.FIFO_DEPTH(4), .IDLE_BYTE(8'hFF)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .spi_sclk_i    (sclk),
    .spi_ss_i      (ss),
    .spi_mosi_i    (mosi),
    .spi_miso_o    (miso),
    .spi_miso_oe_o (miso_oe),
    .rx_data_o     (rx_data),
    .rx_valid_o    (rx_valid),
    .rx_ready_i    (rx_ready),
    .tx_data_i     (tx_data),
    .tx_valid_i    (tx_valid),
    .tx_ready_o    (tx_ready),
    .overrun_o     (overrun),
    .underrun_o    (underrun),
    .frame_err_o   (frame_err),
    .clr_flags_i   (clr_flags)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (frame_err) err_cnt++;

  initial begin
    #500us;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic frame_begin();
    ss = 1'b0;
    wait_n(8);
  endtask

  // Mode-0 master: drive MOSI, sample MISO at the rising edge.
  // With last set, SS rises together with the final falling edge.
  task automatic spi_bits(input logic [7:0] b, input int nb,
                          input bit last, output logic [7:0] got);
    got = 8'h00;
    for (int i = 0; i < nb; i++) begin
      mosi = b[7-i];
      wait_n(4);
      got  = {got[6:0], miso};
      sclk = 1'b1;
      wait_n(4);
      sclk = 1'b0;
      if (last && i == nb - 1) ss = 1'b1;
    end
    if (last) wait_n(8);
  endtask

  task automatic tx_write(input logic [7:0] d);
    tx_data  = d;
    tx_valid = 1'b1;
    wait_n(1);
    tx_valid = 1'b0;
  endtask

  task automatic pop_check(input string tag, input logic [7:0] exp);
    check({tag, "_valid"}, 32'(rx_valid), 32'd1);
    check({tag, "_data"}, 32'(rx_data), 32'(exp));
    rx_ready = 1'b1;
    wait_n(1);
    rx_ready = 1'b0;
  endtask

  task automatic clear_flags();
    clr_flags = 1'b1;
    wait_n(1);
    clr_flags = 1'b0;
  endtask

  function automatic logic [31:0] out_vec();
    return 32'({miso, miso_oe, rx_valid, rx_data, tx_ready,
                overrun, underrun, frame_err});
  endfunction

  localparam logic [31:0] RESET_VEC = 32'h0000_0008;

  logic [7:0] g1, g2;
  int         e0;

  initial begin
    rst = 1'b1; sclk = 1'b0; ss = 1'b1; mosi = 1'b0;
    rx_ready = 1'b0; tx_data = 8'h00; tx_valid = 1'b0;
    clr_flags = 1'b0;
    wait_n(3);
    check("reset_outputs", out_vec(), RESET_VEC);
    rst = 1'b0;
    wait_n(4);

    frame_begin();
    spi_bits(8'hE7, 3, 1'b0, g1);
    check("midframe_oe", 32'(miso_oe), 32'd1);
    rst = 1'b1;
    wait_n(1);
    check("midframe_reset", out_vec(), RESET_VEC);
    sclk = 1'b0;
    ss   = 1'b1;
    wait_n(4);
    rst = 1'b0;
    wait_n(4);

    tx_write(8'hA5);
    check("single_txfull", 32'(tx_ready), 32'd0);
    frame_begin();
    check("single_oe", 32'(miso_oe), 32'd1);
    check("single_txempty", 32'(tx_ready), 32'd1);
    spi_bits(8'h3C, 8, 1'b1, g1);
    check("single_miso", 32'(g1), 32'hA5);
    check("single_underrun", 32'(underrun), 32'd0);
    check("single_oe_off", 32'(miso_oe), 32'd0);
    pop_check("single_rx", 8'h3C);
    check("single_empty", 32'(rx_valid), 32'd0);

    frame_begin();
    spi_bits(8'hC3, 8, 1'b0, g1);
    spi_bits(8'h5A, 8, 1'b1, g2);
    check("empty_b0", 32'(g1), 32'hFF);
    check("empty_b1", 32'(g2), 32'hFF);
    check("empty_underrun", 32'(underrun), 32'd1);
    clear_flags();
    check("empty_clr", 32'(underrun), 32'd0);
    pop_check("empty_rx0", 8'hC3);
    pop_check("empty_rx1", 8'h5A);

    frame_begin();
    for (int k = 1; k <= 5; k++)
      spi_bits(8'(k), 8, k == 5, g1);
    check("ovr_flag", 32'(overrun), 32'd1);
    for (int k = 1; k <= 4; k++)
      pop_check($sformatf("ovr_rx%0d", k), 8'(k));
    check("ovr_empty", 32'(rx_valid), 32'd0);
    clear_flags();
    check("ovr_clr", 32'(overrun), 32'd0);

    e0 = err_cnt;
    frame_begin();
    spi_bits(8'hF0, 5, 1'b1, g1);
    check("abort_pulse", 32'(err_cnt - e0), 32'd1);
    check("abort_nopush", 32'(rx_valid), 32'd0);
    frame_begin();
    spi_bits(8'h11, 8, 1'b1, g1);
    check("abort_noerr", 32'(err_cnt - e0), 32'd1);
    pop_check("abort_next", 8'h11);
    clear_flags();

    tx_write(8'h12);
    frame_begin();
    fork
      begin
        spi_bits(8'hAA, 8, 1'b0, g1);
        spi_bits(8'h55, 8, 1'b1, g2);
      end
      begin
        wait_n(20);
        tx_write(8'h34);
      end
    join
    check("b2b_miso0", 32'(g1), 32'h12);
    check("b2b_miso1", 32'(g2), 32'h34);
    check("b2b_underrun", 32'(underrun), 32'd0);
    check("b2b_txready", 32'(tx_ready), 32'd1);
    pop_check("b2b_rx0", 8'hAA);
    pop_check("b2b_rx1", 8'h55);
    check("b2b_empty", 32'(rx_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
